prg_bank_translator: RTL and testbench
======================================

// Module: prg_bank_translator
// PURPOSE
//  Parametrised CPU-side PRG bank unit, successor to the fixed base/mask PRG address path in the cartridge top level.
//  Holds NUM_BANKS bank registers and a mode register written through $8000-$DFFF.
//  Translates CPU $8000-$FFFF into a flash page as base | (page & ~mask).
//  Adds a power-on hold counter, four page-layout modes and a registered write acknowledge.
// PARAMETERS
//  NUM_BANKS    4   bank registers, 1..4; the register index uses clog2(NUM_BANKS) low address bits
//  BANK_W       8   width of each bank register, <= OUT_W
//  OUT_W        14  width of the page output (cpu_addr_out[26:13])
//  INIT_CYCLES  15  m2 cycles after reset before writes are accepted, >= 1
// PORTS
//  m2            in   1      CPU M2; the only clock; all state updates on posedge
//  reset_n       in   1      asynchronous, active-low reset
//  romsel        in   1      low = CPU $8000-$FFFF access
//  cpu_rw_in     in   1      1 = read, 0 = write
//  cpu_addr_in   in   15     CPU A14..A0
//  cpu_data_in   in   8      CPU data bus (input only)
//  base_in       in   OUT_W  outer-bank base page
//  mask_in       in   OUT_W  page bits forced to the base (1 = masked)
//  cpu_addr_out  out  OUT_W  translated 8 KiB page, combinational
//  init_done     out  1      high once the hold counter reaches 0
//  write_ack     out  1      one-cycle pulse after an accepted register write
// BEHAVIOUR
//  Reset values:
//   - bank[*] = 0, mode = 0, hold counter = INIT_CYCLES
//   - init_done = 0, write_ack = 0, cpu_addr_out = base_in
//  Hold counter:
//   - decrements once per posedge m2 and saturates at 0
//   - init_done = (counter == 0)
//   - while init_done = 0, cpu_addr_out = base_in and all writes are ignored
//  Write accepted at posedge m2 when init_done, !romsel and !cpu_rw_in:
//   - A14..13 = 00: bank[A[idx-1:0]] <= data[BANK_W-1:0], zero-extended when BANK_W > 8
//   - A14..13 = 01: mode <= data[1:0]
//   - A14..13 = 10: lock, only with BANK_LOCK_EN; otherwise the write is ignored and raises no write_ack
//   - A14..13 = 11: ignored, no write_ack
//   - write_ack = 1 in the cycle after an accepted write, otherwise 0
//  New register contents drive cpu_addr_out from the first access after the write edge (0 cycles of extra latency).
//  Page select uses s = A14..13; b(i) = bank[i mod NUM_BANKS]:
//   - mode 0 (32K): page = {b(0)[BANK_W-3:0], s}
//   - mode 1 (16K): s[1]=0 -> {b(0), s[0]}; s[1]=1 -> {all ones, s[0]} (last 16K fixed)
//   - mode 2 (8K): page = b(s); s=3 -> all ones when NUM_BANKS < 4
//   - mode 3: as mode 2 with slots 0 and 2 exchanged
//  Width rule:
//   - page is zero-extended or truncated to OUT_W
//   - cpu_addr_out = base_in | (page & ~mask_in)
//   - mask_in all ones -> cpu_addr_out = base_in
//  Simultaneous events: reset_n low overrides all state, including a write in the same edge. Reset asserted mid-hold restarts the count.
// CONFIGURATION
//  BANK_LOCK_EN defined:
//   - a write to $C000-$DFFF with data[7]=1 sets lock and pulses write_ack
//   - while locked, bank and mode writes are ignored with no write_ack
//   - only reset_n clears lock
//  BANK_LOCK_EN undefined: no lock flop; $C000-$DFFF writes have no effect.
// STRUCTURE
//  Package coolgirl_bank_pkg holds:
//   - mode encodings MODE_32K, MODE_16K, MODE_8K, MODE_8K_SWAP
//   - region decodes REG_BANK = 2'b00, REG_MODE = 2'b01, REG_LOCK = 2'b10
//  Sub-module power_on_hold_counter(m2, reset_n, done), parametrised by INIT_CYCLES.
//  Bank file, decode and mux stay in this module.
// TESTING
//  1. Hold: reset_n 0 -> 1; write bank0 = 5 at cycle 3 -> ignored, init_done low for 15 cycles, cpu_addr_out = base_in.
//  2. 8K mode: mode = 2, banks = 3/7/9/0x1F, base 0, mask 0, read A14..13 = 2 -> out = 9; next cycle write_ack = 1.
//  3. 16K mode: bank0 = 4, mode = 1 -> s=1 gives 9; s=3 gives 0x3FFF (OUT_W = 14, mask 0).
//  4. Outer bank: base = 0x0100, mask = 0x3FF0, mode 2, bank2 = 0x2A -> out = 0x010A.
//  5. Lock (BANK_LOCK_EN): write $C000 = 0x80, then bank1 = 6 -> bank1 unchanged, no write_ack; reset_n pulse -> lock cleared, bank1 = 0.
//  6. Async reset mid-write: reset_n falls while m2 is high -> outputs return to reset values at once; the write is not latched.

Source files
------------

// File: rtl/coolgirl_bank_pkg.sv
// Shared encodings for the CPU-side PRG bank unit: page-layout modes and
// register-region decodes selected by CPU A14..A13 inside $8000-$DFFF.
package coolgirl_bank_pkg;

  typedef enum logic [1:0] {
    MODE_32K     = 2'd0,
    MODE_16K     = 2'd1,
    MODE_8K      = 2'd2,
    MODE_8K_SWAP = 2'd3
  } prg_mode_e;

  localparam logic [1:0] REG_BANK = 2'b00;
  localparam logic [1:0] REG_MODE = 2'b01;
  localparam logic [1:0] REG_LOCK = 2'b10;

endpackage

// File: rtl/power_on_hold_counter.sv
// Counts INIT_CYCLES rising edges of m2 after reset, then holds done high.
// Re-asserting reset_n at any point restarts the count.
module power_on_hold_counter #(
  parameter int INIT_CYCLES = 15
) (
  input  logic m2,
  input  logic reset_n,
  output logic done
);

  localparam int CNT_W = $clog2(INIT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge m2 or negedge reset_n) begin
    if (!reset_n) begin
      count <= CNT_W'(INIT_CYCLES);
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/prg_bank_translator.sv
// CPU-side PRG bank unit: bank/mode registers at $8000-$DFFF and translation of
// $8000-$FFFF into an outer-banked flash page. Optional lock: `BANK_LOCK_EN.
module prg_bank_translator
  import coolgirl_bank_pkg::*;
#(
  parameter int NUM_BANKS   = 4,
  parameter int BANK_W      = 8,
  parameter int OUT_W       = 14,
  parameter int INIT_CYCLES = 15
) (
  input  logic             m2,
  input  logic             reset_n,
  input  logic             romsel,
  input  logic             cpu_rw_in,
  input  logic [14:0]      cpu_addr_in,
  input  logic [7:0]       cpu_data_in,
  input  logic [OUT_W-1:0] base_in,
  input  logic [OUT_W-1:0] mask_in,
  output logic [OUT_W-1:0] cpu_addr_out,
  output logic             init_done,
  output logic             write_ack
);

  localparam int IDX_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int PAGE_W = (OUT_W > BANK_W + 1) ? OUT_W : BANK_W + 1;

  logic [BANK_W-1:0] bank [NUM_BANKS];
  prg_mode_e         mode;
  logic [1:0]        region;
  logic [IDX_W-1:0]  wr_idx;
  logic [BANK_W-1:0] bank_wdata;
  logic [BANK_W+7:0] data_ext;
  logic              wr_en, bank_we, mode_we, lock_we, locked;

  power_on_hold_counter #(.INIT_CYCLES(INIT_CYCLES)) u_hold (
    .m2      (m2),
    .reset_n (reset_n),
    .done    (init_done)
  );

  assign region     = cpu_addr_in[14:13];
  assign wr_idx     = cpu_addr_in[IDX_W-1:0];
  assign data_ext   = {{BANK_W{1'b0}}, cpu_data_in};
  assign bank_wdata = data_ext[BANK_W-1:0];
  assign wr_en      = init_done && !romsel && !cpu_rw_in;
  assign bank_we    = wr_en && (region == REG_BANK) && !locked;
  assign mode_we    = wr_en && (region == REG_MODE) && !locked;

`ifdef BANK_LOCK_EN
  // Lock is sticky until reset: software can freeze the PRG layout for a game.
  assign lock_we = wr_en && (region == REG_LOCK) && cpu_data_in[7];

  always_ff @(posedge m2 or negedge reset_n) begin
    if (!reset_n) begin
      locked <= 1'b0;
    end else if (lock_we) begin
      locked <= 1'b1;
    end
  end
`else
  assign lock_we = 1'b0;
  assign locked  = 1'b0;
`endif

  // NOTE: the bank file is small and its reset value is architecturally
  // visible, so every entry is reset rather than left as uninitialised RAM.
  always_ff @(posedge m2 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_BANKS; i++) bank[i] <= '0;
      mode      <= MODE_32K;
      write_ack <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        if (bank_we && (NUM_BANKS == 1 || int'(wr_idx) == i)) bank[i] <= bank_wdata;
      end
      if (mode_we) mode <= prg_mode_e'(cpu_data_in[1:0]);
      write_ack <= bank_we || mode_we || lock_we;
    end
  end

  logic [1:0]        s, slot;
  logic [BANK_W-1:0] b_sel;
  logic [PAGE_W-1:0] page;

  assign s = cpu_addr_in[14:13];

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    slot  = s;
    b_sel = '0;
    page  = '0;
    if (mode == MODE_8K_SWAP && !s[0]) slot = {~s[1], s[0]};
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (i == int'(slot) % NUM_BANKS) b_sel = bank[i];
    end
    case (mode)
      MODE_32K: page = PAGE_W'({bank[0][BANK_W-3:0], s});
      MODE_16K: page = s[1] ? {{(PAGE_W-1){1'b1}}, s[0]} : PAGE_W'({bank[0], s[0]});
      MODE_8K, MODE_8K_SWAP: begin
        if (slot == 2'd3 && NUM_BANKS < 4) page = '1;
        else                               page = PAGE_W'(b_sel);
      end
      default: page = '0;
    endcase
  end

  assign cpu_addr_out = init_done ? (base_in | (OUT_W'(page) & ~mask_in)) : base_in;

  // Address bits above the register index and data bits above the bank width
  // have no function here.
  logic unused_bits;
  assign unused_bits = ^{cpu_addr_in, cpu_data_in, page};

endmodule

// File: tb/tb_prg_bank_translator.sv
// Directed bench for prg_bank_translator: hold period, all page modes, outer
// bank masking, ignored regions, optional lock and asynchronous reset.
module tb_prg_bank_translator;

  logic        m2 = 1'b0;
  logic        reset_n;
  logic        romsel;
  logic        cpu_rw_in;
  logic [14:0] cpu_addr_in;
  logic [7:0]  cpu_data_in;
  logic [13:0] base_in;
  logic [13:0] mask_in;
  logic [13:0] cpu_addr_out;
  logic        init_done;
  logic        write_ack;

  int errors = 0;
  int checks = 0;

  prg_bank_translator dut (
    .m2           (m2),
    .reset_n      (reset_n),
    .romsel       (romsel),
    .cpu_rw_in    (cpu_rw_in),
    .cpu_addr_in  (cpu_addr_in),
    .cpu_data_in  (cpu_data_in),
    .base_in      (base_in),
    .mask_in      (mask_in),
    .cpu_addr_out (cpu_addr_out),
    .init_done    (init_done),
    .write_ack    (write_ack)
  );

  always #5 m2 = ~m2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    romsel      = 1'b1;
    cpu_rw_in   = 1'b1;
    cpu_addr_in = 15'h0000;
    cpu_data_in = 8'h00;
  endtask

  // Called at a negedge; drives one write across the next posedge and returns
  // write_ack as seen at the following negedge.
  task automatic do_write(input logic [14:0] a, input logic [7:0] d, output logic ack);
    romsel      = 1'b0;
    cpu_rw_in   = 1'b0;
    cpu_addr_in = a;
    cpu_data_in = d;
    @(negedge m2);
    ack = write_ack;
    set_idle();
  endtask

  task automatic do_read(input logic [1:0] s, output logic [13:0] out);
    romsel      = 1'b0;
    cpu_rw_in   = 1'b1;
    cpu_addr_in = {s, 13'h0000};
    #1 out = cpu_addr_out;
    @(negedge m2);
    set_idle();
  endtask

  // Releases reset at a negedge and waits out the hold period.
  task automatic release_and_wait();
    reset_n = 1'b1;
    repeat (15) @(negedge m2);
    check("hold_done", init_done, 1'b1);
  endtask

  logic        ack;
  logic [13:0] out;

  initial begin
    set_idle();
    reset_n = 1'b0;
    base_in = 14'h0123;
    mask_in = 14'h0000;
    @(negedge m2);
    #1;
    check("rst_init_done", init_done, 1'b0);
    check("rst_ack", write_ack, 1'b0);
    check("rst_out", cpu_addr_out, 14'h0123);
    @(negedge m2);

    // Hold period with a write attempt during cycle 3.
    reset_n = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      if (c == 3) begin
        romsel = 1'b0; cpu_rw_in = 1'b0; cpu_addr_in = 15'h0000; cpu_data_in = 8'h05;
      end else begin
        set_idle();
      end
      @(negedge m2);
      check($sformatf("hold_done_c%0d", c), init_done, (c == 15));
      check($sformatf("hold_ack_c%0d", c), write_ack, 1'b0);
      if (c < 15) check($sformatf("hold_out_c%0d", c), cpu_addr_out, 14'h0123);
    end
    set_idle();
    do_read(2'd0, out);
    check("hold_write_ignored", out, 14'h0123);

    // 8K mode with banks 3/7/9/0x1F.
    base_in = 14'h0000;
    do_write(15'h2000, 8'h02, ack); check("ack_mode", ack, 1'b1);
    do_write(15'h0000, 8'h03, ack); check("ack_bank0", ack, 1'b1);
    do_write(15'h0001, 8'h07, ack);
    do_write(15'h0002, 8'h09, ack);
    do_write(15'h0003, 8'h1F, ack);
    do_read(2'd2, out); check("m8k_s2", out, 14'h0009);
    check("ack_after_read", write_ack, 1'b0);
    do_read(2'd0, out); check("m8k_s0", out, 14'h0003);
    do_read(2'd1, out); check("m8k_s1", out, 14'h0007);
    do_read(2'd3, out); check("m8k_s3", out, 14'h001F);

    // 8K with slots 0 and 2 exchanged.
    do_write(15'h2000, 8'h03, ack);
    do_read(2'd0, out); check("swap_s0", out, 14'h0009);
    do_read(2'd2, out); check("swap_s2", out, 14'h0003);
    do_read(2'd1, out); check("swap_s1", out, 14'h0007);

    // 32K mode: {bank0[5:0], s} with bank0 = 3.
    do_write(15'h2000, 8'h00, ack);
    do_read(2'd2, out); check("m32k_s2", out, 14'h000E);

    // 16K mode with bank0 = 4.
    do_write(15'h0000, 8'h04, ack);
    do_write(15'h2000, 8'h01, ack);
    do_read(2'd1, out); check("m16k_s1", out, 14'h0009);
    do_read(2'd0, out); check("m16k_s0", out, 14'h0008);
    do_read(2'd3, out); check("m16k_s3", out, 14'h3FFF);
    do_read(2'd2, out); check("m16k_s2", out, 14'h3FFE);

    // Outer bank masking.
    base_in = 14'h0100;
    mask_in = 14'h3FF0;
    do_write(15'h2000, 8'h02, ack);
    do_write(15'h0002, 8'h2A, ack);
    do_read(2'd2, out); check("outer_bank", out, 14'h010A);
    mask_in = 14'h3FFF;
    do_read(2'd2, out); check("mask_all", out, 14'h0100);
    base_in = 14'h0000;
    mask_in = 14'h0000;

    // Ignored writes: region 11, romsel high, read cycle.
    do_write(15'h6001, 8'h55, ack); check("ack_region3", ack, 1'b0);
    romsel = 1'b1; cpu_rw_in = 1'b0; cpu_addr_in = 15'h0001; cpu_data_in = 8'h44;
    @(negedge m2);
    check("ack_romsel_hi", write_ack, 1'b0);
    romsel = 1'b0; cpu_rw_in = 1'b1;
    @(negedge m2);
    set_idle();
    do_read(2'd1, out); check("bank1_kept", out, 14'h0007);

`ifdef BANK_LOCK_EN
    do_write(15'h4000, 8'h80, ack); check("ack_lock", ack, 1'b1);
    do_write(15'h0001, 8'h06, ack); check("ack_locked_bank", ack, 1'b0);
    do_write(15'h2000, 8'h00, ack); check("ack_locked_mode", ack, 1'b0);
    do_read(2'd1, out); check("locked_bank1", out, 14'h0007);
    reset_n = 1'b0;
    @(negedge m2);
    release_and_wait();
    do_write(15'h2000, 8'h02, ack); check("ack_unlocked", ack, 1'b1);
    do_read(2'd1, out); check("bank1_after_rst", out, 14'h0000);
    do_write(15'h0001, 8'h07, ack);
`else
    do_write(15'h4000, 8'h80, ack); check("ack_lock_absent", ack, 1'b0);
    do_write(15'h0001, 8'h06, ack); check("ack_bank_unlocked", ack, 1'b1);
    do_read(2'd1, out); check("bank1_written", out, 14'h0006);
`endif

    // Asynchronous reset while m2 is high, right after a write edge.
    do_write(15'h2000, 8'h00, ack);
    base_in = 14'h0040;
    romsel = 1'b0; cpu_rw_in = 1'b0; cpu_addr_in = 15'h0000; cpu_data_in = 8'h3C;
    @(posedge m2);
    #2 reset_n = 1'b0;
    #1;
    check("async_init_done", init_done, 1'b0);
    check("async_ack", write_ack, 1'b0);
    check("async_out", cpu_addr_out, 14'h0040);
    @(negedge m2);
    set_idle();
    release_and_wait();
    do_read(2'd0, out); check("async_bank0_clear", out, 14'h0040);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
